// File: rtl/asp_pkg.sv
// Shared ASP definitions: transmit FSM states and default frame geometry,
// used by the ASP top, the transmit scheduler and the receive path.
package asp_pkg;

  localparam int DEFAULT_DATA_SIZE = 32;
  localparam int DEFAULT_TAG_SIZE  = 8;
  localparam int FRAME_W           = DEFAULT_DATA_SIZE + DEFAULT_TAG_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    SEND_DATA,
    WAIT_ACK,
    SEND_ACK
  } asp_tx_state_t;

endpackage

// File: rtl/asp_ack_timer.sv
// ACK wait timer: cleared when a frame goes out, counts while enabled and
// holds at TIMEOUT_CYCLES-1, where expire stays asserted.
module asp_ack_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Saturating at the terminal value means the counter never wraps between clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/asp_tx_scheduler.sv
// ASP transmit scheduler: arbitrates data frames and ACK responses onto the network
// output and keeps one word outstanding until acknowledged. Define ASP_TX_RETRY_EN to retransmit on timeout.
module asp_tx_scheduler
  import asp_pkg::*;
#(
  parameter int DATA_SIZE      = DEFAULT_DATA_SIZE,
  parameter int TAG_SIZE       = DEFAULT_TAG_SIZE,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_req_in,
  input  logic [DATA_SIZE-1:0]          tx_data_in,
  output logic                          tx_grant_out,
  input  logic                          ack_req_in,
  input  logic [TAG_SIZE-1:0]           ack_tag_in,
  output logic                          ack_grant_out,
  input  logic                          network_ACK_in,
  input  logic [TAG_SIZE-1:0]           network_ack_tag_in,
  output logic                          network_data_ready_out,
  output logic                          network_ACK_out,
  output logic [DATA_SIZE+TAG_SIZE-1:0] network_data_tag_out,
  output logic                          busy_out,
  output logic                          timeout_error_out
);

  if (TIMEOUT_CYCLES < 2 || MAX_RETRIES < 0) begin : g_param_check
    $error("asp_tx_scheduler: TIMEOUT_CYCLES must be >= 2 and MAX_RETRIES >= 0");
  end

  asp_tx_state_t       state;
  logic [TAG_SIZE-1:0] cur_tag;
  logic                word_pending;
  logic                expire;
  logic                ack_match;
  logic                timeout_now;
  logic                retry_now;

  asp_ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ack_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state == SEND_DATA),
    .enable(state == WAIT_ACK),
    .expire(expire)
  );

  assign ack_match   = (state == WAIT_ACK) && network_ACK_in && (network_ack_tag_in == cur_tag);
  assign timeout_now = (state == WAIT_ACK) && expire && !ack_match;

  // Grants are combinational; gating with reset keeps every output low while reset is held.
  // A timeout takes precedence over an ACK request, which simply waits to be granted later.
  assign ack_grant_out = !reset && ack_req_in &&
                         ((state == IDLE) || ((state == WAIT_ACK) && !ack_match && !expire));
  assign tx_grant_out  = !reset && (state == IDLE) && tx_req_in && !ack_req_in;
  assign busy_out      = (state != IDLE);

`ifdef ASP_TX_RETRY_EN
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic [DATA_SIZE-1:0] word_q;
  logic [RETRY_W-1:0]   retry_cnt;

  assign retry_now = timeout_now && (retry_cnt < RETRY_W'(MAX_RETRIES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q    <= '0;
      retry_cnt <= '0;
    end else if (tx_grant_out) begin
      word_q    <= tx_data_in;
      retry_cnt <= '0;
    end else if (retry_now) begin
      retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end
`else
  assign retry_now = 1'b0;
`endif

  // Main FSM; every network output is registered on the transition into its send state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      cur_tag                <= '0;
      word_pending           <= 1'b0;
      network_data_ready_out <= 1'b0;
      network_ACK_out        <= 1'b0;
      network_data_tag_out   <= '0;
      timeout_error_out      <= 1'b0;
    end else begin
      network_data_ready_out <= 1'b0;
      network_ACK_out        <= 1'b0;
      network_data_tag_out   <= '0;
      timeout_error_out      <= 1'b0;
      case (state)
        IDLE: begin
          if (ack_grant_out) begin
            network_ACK_out      <= 1'b1;
            network_data_tag_out <= {{DATA_SIZE{1'b0}}, ack_tag_in};
            state                <= SEND_ACK;
          end else if (tx_grant_out) begin
            network_data_ready_out <= 1'b1;
            network_data_tag_out   <= {tx_data_in, cur_tag};
            word_pending           <= 1'b1;
            state                  <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_match) begin
            cur_tag      <= cur_tag + TAG_SIZE'(1);
            word_pending <= 1'b0;
            state        <= IDLE;
          end else if (retry_now) begin
`ifdef ASP_TX_RETRY_EN
            network_data_ready_out <= 1'b1;
            network_data_tag_out   <= {word_q, cur_tag};
`endif
            state <= SEND_DATA;
          end else if (timeout_now) begin
            timeout_error_out <= 1'b1;
            cur_tag           <= cur_tag + TAG_SIZE'(1);
            word_pending      <= 1'b0;
            state             <= IDLE;
          end else if (ack_grant_out) begin
            network_ACK_out      <= 1'b1;
            network_data_tag_out <= {{DATA_SIZE{1'b0}}, ack_tag_in};
            state                <= SEND_ACK;
          end
        end
        SEND_ACK: begin
          state <= word_pending ? WAIT_ACK : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asp_tx_scheduler.sv
// Self-checking bench for asp_tx_scheduler (TIMEOUT_CYCLES=8, MAX_RETRIES=2); frames are
// scoreboarded in order of request and checked by a monitor as they appear on the network outputs.
module tb_asp_tx_scheduler;

  localparam int DW = 32;
  localparam int TW = 8;
  localparam int TO = 8;
  localparam int MR = 2;
`ifdef ASP_TX_RETRY_EN
  localparam int RESENDS = MR;
`else
  localparam int RESENDS = 0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           tx_req_in = 1'b0;
  logic [DW-1:0]  tx_data_in = '0;
  logic           tx_grant_out;
  logic           ack_req_in = 1'b0;
  logic [TW-1:0]  ack_tag_in = '0;
  logic           ack_grant_out;
  logic           network_ACK_in = 1'b0;
  logic [TW-1:0]  network_ack_tag_in = '0;
  logic           network_data_ready_out;
  logic           network_ACK_out;
  logic [DW+TW-1:0] network_data_tag_out;
  logic           busy_out;
  logic           timeout_error_out;

  asp_tx_scheduler #(
    .DATA_SIZE(DW), .TAG_SIZE(TW), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_req_in(tx_req_in), .tx_data_in(tx_data_in), .tx_grant_out(tx_grant_out),
    .ack_req_in(ack_req_in), .ack_tag_in(ack_tag_in), .ack_grant_out(ack_grant_out),
    .network_ACK_in(network_ACK_in), .network_ack_tag_in(network_ack_tag_in),
    .network_data_ready_out(network_data_ready_out), .network_ACK_out(network_ACK_out),
    .network_data_tag_out(network_data_tag_out), .busy_out(busy_out),
    .timeout_error_out(timeout_error_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           is_ack;
    logic [DW+TW-1:0] frame;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW+TW+1:0] mon_got;
  logic [DW+TW+1:0] mon_want;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [TW-1:0] exp_tag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every frame on the network must match the oldest expected frame.
  always @(negedge clk) begin
    if (!reset && (network_data_ready_out || network_ACK_out)) begin
      checks++;
      mon_got = {network_ACK_out, network_data_ready_out, network_data_tag_out};
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL frame_unexpected @cyc %0d: got ack/data/frame=%h, required no frame", cyc, mon_got);
      end else begin
        mon_e    = exp_q.pop_front();
        mon_want = {mon_e.is_ack, !mon_e.is_ack, mon_e.frame};
        if (mon_got !== mon_want) begin
          errors++;
          $display("[TB] FAIL frame @cyc %0d: got ack/data/frame=%h, required %h", cyc, mon_got, mon_want);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Called at a negedge; returns at the negedge of the SEND_DATA cycle.
  task automatic request_tx(input logic [DW-1:0] d, output int gcyc, output int waited);
    waited = 0;
    tx_req_in  = 1'b1;
    tx_data_in = d;
    exp_q.push_back({1'b0, d, exp_tag});
    #1;
    while (tx_grant_out !== 1'b1 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    checks++;
    if (tx_grant_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tx_grant_wait: got grant=%b after %0d cycles, required 1", tx_grant_out, waited);
    end
    gcyc = cyc;
    @(posedge clk); #1;
    tx_req_in  = 1'b0;
    tx_data_in = '0;
    @(negedge clk);
  endtask

  task automatic send_and_ack(input logic [DW-1:0] d);
    int g, w;
    request_tx(d, g, w);
    @(negedge clk);
    network_ACK_in     = 1'b1;
    network_ack_tag_in = exp_tag;
    @(negedge clk);
    network_ACK_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_completes tag %h: got busy=%b, required 0", exp_tag, busy_out);
    end
    exp_tag = exp_tag + 8'd1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_grant_out, ack_grant_out, network_data_ready_out, network_ACK_out,
         network_data_tag_out, busy_out, timeout_error_out} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b frame=%h, required all 0", busy_out, network_data_tag_out);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_out !== 1'b0 || network_data_ready_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got busy=%b ready=%b, required 0 0", busy_out, network_data_ready_out);
    end
  endtask

  task automatic test_basic;
    int g, w;
    request_tx(32'hA5A5A5A5, g, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("[TB] FAIL basic_grant_cycle: got grant after %0d cycles, required 0", w);
    end
    checks++;
    if (network_data_ready_out !== 1'b1 || network_data_tag_out !== {32'hA5A5A5A5, 8'h00}) begin
      errors++;
      $display("[TB] FAIL basic_frame_latency: got ready=%b frame=%h, required 1 a5a5a5a500", network_data_ready_out, network_data_tag_out);
    end
    while (cyc < g + 4) @(negedge clk);
    network_ACK_in     = 1'b1;
    network_ack_tag_in = 8'h00;
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_busy_wait: got busy=%b, required 1", busy_out);
    end
    @(negedge clk);
    network_ACK_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_ack_idle: got busy=%b, required 0", busy_out);
    end
    exp_tag = exp_tag + 8'd1;
  endtask

  task automatic test_ack_priority;
    int g;
    ack_req_in = 1'b1;
    ack_tag_in = 8'h3C;
    tx_req_in  = 1'b1;
    tx_data_in = 32'h1234_5678;
    exp_q.push_back({1'b1, 32'h0, 8'h3C});
    exp_q.push_back({1'b0, 32'h1234_5678, exp_tag});
    #1;
    checks++;
    if (ack_grant_out !== 1'b1 || tx_grant_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_grants: got ack_grant=%b tx_grant=%b, required 1 0", ack_grant_out, tx_grant_out);
    end
    g = cyc;
    @(posedge clk); #1;
    ack_req_in = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_grant_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_no_grant_in_send_ack: got tx_grant=%b, required 0", tx_grant_out);
    end
    @(negedge clk);
    checks++;
    if (tx_grant_out !== 1'b1 || cyc != g + 2) begin
      errors++;
      $display("[TB] FAIL prio_tx_grant_after_ack: got tx_grant=%b at +%0d, required 1 at +2", tx_grant_out, cyc - g);
    end
    @(posedge clk); #1;
    tx_req_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    network_ACK_in     = 1'b1;
    network_ack_tag_in = exp_tag;
    @(negedge clk);
    network_ACK_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_ack_idle: got busy=%b, required 0", busy_out);
    end
    exp_tag = exp_tag + 8'd1;
  endtask

  task automatic test_ack_detour;
    int g, w;
    while (exp_tag != 8'h05) send_and_ack(32'hC0DE_0000 | 32'(exp_tag));
    request_tx(32'hDE7A_0005, g, w);
    @(negedge clk);
    ack_req_in = 1'b1;
    ack_tag_in = 8'h77;
    exp_q.push_back({1'b1, 32'h0, 8'h77});
    #1;
    checks++;
    if (ack_grant_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL detour_ack_grant: got %b, required 1", ack_grant_out);
    end
    @(posedge clk); #1;
    ack_req_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    network_ACK_in     = 1'b1;
    network_ack_tag_in = 8'h06;
    @(negedge clk);
    network_ACK_in = 1'b0;
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL detour_wrong_tag_ignored: got busy=%b, required 1", busy_out);
    end
    // With the timer frozen through SEND_ACK, its last count falls in cycle g+10.
    while (cyc < g + 10) @(negedge clk);
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL detour_timer_frozen: got busy=%b at +10, required 1", busy_out);
    end
    network_ACK_in     = 1'b1;
    network_ack_tag_in = 8'h05;
    @(negedge clk);
    network_ACK_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || timeout_error_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL detour_ack_at_timeout: got busy=%b err=%b, required 0 0", busy_out, timeout_error_out);
    end
    exp_tag = exp_tag + 8'd1;
  endtask

  task automatic test_timeout;
    int g, w, target;
    request_tx(32'hDEAD_BEEF, g, w);
    for (int k = 0; k < RESENDS; k++) exp_q.push_back({1'b0, 32'hDEAD_BEEF, exp_tag});
    for (int k = 1; k <= RESENDS; k++) begin
      while (cyc < g + 1 + 9 * k) @(negedge clk);
      checks++;
      if (network_data_ready_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL timeout_resend_%0d: got ready=%b at +%0d, required 1", k, network_data_ready_out, cyc - g);
      end
    end
    target = g + 9 * (RESENDS + 1) + 1;
    while (cyc < target - 1) @(negedge clk);
    checks++;
    if (timeout_error_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_early: got err=%b at +%0d, required 0", timeout_error_out, cyc - g);
    end
    @(negedge clk);
    checks++;
    if (timeout_error_out !== 1'b1 || busy_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_error: got err=%b busy=%b at +%0d, required 1 0", timeout_error_out, busy_out, cyc - g);
    end
    exp_tag = exp_tag + 8'd1;
    @(negedge clk);
    checks++;
    if (timeout_error_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_pulse_width: got err=%b, required 0", timeout_error_out);
    end
  endtask

  task automatic test_tag_wrap;
    int g, w;
    while (exp_tag != 8'hFF) send_and_ack($urandom);
    send_and_ack(32'hFFFF_00FF);
    send_and_ack(32'h0000_0100);
    request_tx(32'h7130_0C7E, g, w);
    while (cyc < g + 9) @(negedge clk);
    network_ACK_in     = 1'b1;
    network_ack_tag_in = exp_tag;
    @(negedge clk);
    network_ACK_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || timeout_error_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_ack_in_timeout_cycle: got busy=%b err=%b, required 0 0", busy_out, timeout_error_out);
    end
    exp_tag = exp_tag + 8'd1;
  endtask

  task automatic test_reset_mid_frame;
    int g, w;
    request_tx(32'hBAD0_0001, g, w);
    @(negedge clk);
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_busy_before: got %b, required 1", busy_out);
    end
    reset      = 1'b1;
    tx_req_in  = 1'b1;
    ack_req_in = 1'b1;
    #1;
    checks++;
    if ({tx_grant_out, ack_grant_out, network_data_ready_out, network_ACK_out,
         network_data_tag_out, busy_out, timeout_error_out} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got grants=%b%b busy=%b, required all 0", tx_grant_out, ack_grant_out, busy_out);
    end
    @(negedge clk);
    reset      = 1'b0;
    tx_req_in  = 1'b0;
    ack_req_in = 1'b0;
    exp_tag    = 8'h00;
    send_and_ack(32'h600D_0000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_priority();
    test_ack_detour();
    test_timeout();
    test_tag_wrap();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL frames_missing: got %0d frames still expected, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
